ra_multibank: RTL

Parametrised N-bank reference-tile buffer, the successor to the two-bank RA ping-pong. A DRAM prefetch producer fills banks in ring order while the motion-compensation consumer reads a completed bank through NUM_RD parallel random-access ports. Explicit per-bank ownership (FREE/FILLING/READY/READING) replaces blind toggling, so fills never overwrite a bank under read. Sits between the ref_data DRAM stream and the MC/interpolation datapath.

---
 rtl/ra_multibank.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ra_multibank.sv
`default_nettype none
// ============================================================================
// Module   : ra_multibank
// Purpose  : N-bank reference-tile buffer with per-bank ownership between a
//            ring-ordered DRAM fill producer and a multi-port MC read consumer.
// Revision : 1.0  initial release
// ============================================================================
module ra_multibank #(
    parameter  int DATA_W    = 16,
    parameter  int W         = 16,
    parameter  int H         = 16,
    parameter  int NUM_BANKS = 2,
    parameter  int NUM_RD    = 4,
    localparam int AW        = $clog2(W*H),
    localparam int BW        = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_start,
    output logic                     fill_ready,
    output logic                     filling,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     fill_done,
    input  logic                     rd_start,
    output logic                     rd_avail,
    output logic                     rd_valid,
    output logic [BW-1:0]            rd_bank_sel,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     rd_done,
    output logic [BW:0]              ready_cnt,
    output logic                     wr_err
);

    localparam int            c_DEPTH   = W * H;
    localparam logic [BW-1:0] c_LAST    = BW'(NUM_BANKS - 1);
    localparam logic [1:0]    c_FREE    = 2'd0;
    localparam logic [1:0]    c_FILLING = 2'd1;
    localparam logic [1:0]    c_READY   = 2'd2;
    localparam logic [1:0]    c_READING = 2'd3;

    logic [1:0]        r_state [NUM_BANKS];
    logic [BW-1:0]     r_wr_ptr;
    logic [BW-1:0]     r_rd_ptr;
    logic [BW-1:0]     r_rd_bank_sel;
    logic              r_filling;
    logic              r_rd_valid;
    logic              r_wr_err;
    logic [BW:0]       r_ready_cnt;
    logic [DATA_W-1:0] r_mem [NUM_BANKS][c_DEPTH];

    logic w_fill_ready;
    logic w_rd_avail;
    logic w_fill_acc;
    logic w_fill_fin;
    logic w_rd_acc;
    logic w_rd_rel;
    logic w_err_evt;

    // Ring wrap that also works for non-power-of-two bank counts
    function automatic logic [BW-1:0] f_next(input logic [BW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_fill_ready = (r_state[r_wr_ptr] == c_FREE) && !r_filling;
    assign w_rd_avail   = (r_state[r_rd_ptr] == c_READY) && !r_rd_valid;
    assign w_fill_acc   = fill_start && w_fill_ready;
    assign w_fill_fin   = fill_done && r_filling;
    assign w_rd_acc     = rd_start && w_rd_avail;
    assign w_rd_rel     = rd_done && r_rd_valid;
    assign w_err_evt    = (wr_en && !r_filling) || (fill_done && !r_filling) ||
                          (rd_done && !r_rd_valid);

    // Fill and read handshakes always address distinct banks, so the four
    // state updates below never collide on the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= c_FREE;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rd_bank_sel <= '0;
            r_filling     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_wr_err      <= 1'b0;
            r_ready_cnt   <= '0;
        end else begin
            if (w_fill_acc) begin
                r_state[r_wr_ptr] <= c_FILLING;
                r_filling         <= 1'b1;
            end
            if (w_fill_fin) begin
                r_state[r_wr_ptr] <= c_READY;
                r_filling         <= 1'b0;
                r_wr_ptr          <= f_next(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_state[r_rd_ptr] <= c_READING;
                r_rd_valid        <= 1'b1;
                r_rd_bank_sel     <= r_rd_ptr;
            end
            if (w_rd_rel) begin
                r_state[r_rd_bank_sel] <= c_FREE;
                r_rd_valid             <= 1'b0;
                r_rd_ptr               <= f_next(r_rd_ptr);
            end
            if (w_err_evt) begin
                r_wr_err <= 1'b1;
            end
            case ({w_fill_fin, w_rd_acc})
                2'b10:   r_ready_cnt <= r_ready_cnt + 1'b1;
                2'b01:   r_ready_cnt <= r_ready_cnt - 1'b1;
                default: r_ready_cnt <= r_ready_cnt;
            endcase
        end
    end

    // Tile storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (wr_en && r_filling) begin
            r_mem[r_wr_ptr][wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
            logic [AW-1:0]     w_addr;
            logic [DATA_W-1:0] r_port_data;

            assign w_addr = rd_addr[k*AW +: AW];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_port_data <= '0;
                end else if (r_rd_valid) begin
                    r_port_data <= r_mem[r_rd_bank_sel][w_addr];
                end else begin
                    r_port_data <= '0;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = r_port_data;
        end
    endgenerate

    assign fill_ready  = w_fill_ready;
    assign filling     = r_filling;
    assign rd_avail    = w_rd_avail;
    assign rd_valid    = r_rd_valid;
    assign rd_bank_sel = r_rd_bank_sel;
    assign ready_cnt   = r_ready_cnt;
    assign wr_err      = r_wr_err;

endmodule
`default_nettype wire
